// File: rtl/ex_pipe_pkg.sv
// Shared definitions for the execute-side pipeline registers: control bit map, data field map.
// Consumers use the offsets to pick fields out of the flat ctrl/data bundles.
package ex_pipe_pkg;

    localparam int EX_CTRL_W = 12;
    localparam int EX_DATA_W = 256;
    localparam int EX_FIELD_W = 32;

    // Control bundle bit offsets (two-bit fields name their low bit)
    localparam int CTL_REGWRITE      = 0;
    localparam int CTL_MEMREAD_LO    = 1;
    localparam int CTL_MEMWRITE_LO   = 3;
    localparam int CTL_MEMTOREG      = 5;
    localparam int CTL_JAL           = 6;
    localparam int CTL_JUMP          = 7;
    localparam int CTL_JR            = 8;
    localparam int CTL_SAD           = 9;
    localparam int CTL_CHECK_WCOL_LO = 10;

    typedef struct packed {
        logic [1:0] check_wcol;
        logic       sad;
        logic       jr;
        logic       jump;
        logic       jal;
        logic       memtoreg;
        logic [1:0] memwrite;
        logic [1:0] memread;
        logic       regwrite;
    } ctrl_t;

    // Default data bundle map, in 32-bit field slots from bit 0 upward
    localparam int FLD_ALU_RESULT = 0;
    localparam int FLD_RS_VAL     = 1;
    localparam int FLD_RT_VAL     = 2;
    localparam int FLD_IMM        = 3;
    localparam int FLD_PC_PLUS4   = 4;
    localparam int FLD_SAD_PART0  = 5;
    localparam int FLD_SAD_PART1  = 6;
    localparam int FLD_SAD_PART2  = 7;

    typedef struct packed {
        logic [31:0] sad_part2;
        logic [31:0] sad_part1;
        logic [31:0] sad_part0;
        logic [31:0] pc_plus4;
        logic [31:0] imm;
        logic [31:0] rt_val;
        logic [31:0] rs_val;
        logic [31:0] alu_result;
    } data_t;

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register: valid/ctrl/data loaded from its source when ready, cleared on flush.
// One cycle; holds everything while load is low, so back-pressure is just a held slot.
module pipe_slot #(
    parameter int CTRL_W    = 12,
    parameter int DATA_W    = 256,
    parameter bit ZERO_DATA = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clear,
    input  logic              load,
    input  logic              src_valid,
    input  logic [CTRL_W-1:0] src_ctrl,
    input  logic [DATA_W-1:0] src_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (ZERO_DATA) begin
                data <= '0;
            end
        end else if (load) begin
            valid <= src_valid;
            // A bubble never carries control bits, so downstream can trust ctrl without valid
            ctrl  <= src_valid ? src_ctrl : '0;
            if (src_valid) begin
                data <= src_data;
            end else if (ZERO_DATA) begin
                data <= '0;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage valid/ready register chain with bubble collapse, flush and an occupancy count.
// DEPTH cycles latency, one beat per cycle; empty slots keep filling while the output stalls.
module elastic_pipe_reg
    import ex_pipe_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int CTRL_W    = EX_CTRL_W,
    parameter int DATA_W    = EX_DATA_W,
    parameter bit ZERO_DATA = 1'b0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    logic [DEPTH-1:0]  slot_vld;
    logic [CTRL_W-1:0] slot_ctrl [DEPTH];
    logic [DATA_W-1:0] slot_data [DEPTH];
    logic [DEPTH:0]    rdy;
    logic [OCC_W-1:0]  occ_q;
    logic              in_xfer;
    logic              out_xfer;

    // Ready ripples from the output back: a slot can take a beat if it is empty or moving on
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = !slot_vld[i] | rdy[i+1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic              src_vld;
        logic [CTRL_W-1:0] src_ctrl;
        logic [DATA_W-1:0] src_data;

        if (i == 0) begin : g_head
            assign src_vld  = in_valid;
            assign src_ctrl = in_ctrl;
            assign src_data = in_data;
        end else begin : g_link
            assign src_vld  = slot_vld[i-1];
            assign src_ctrl = slot_ctrl[i-1];
            assign src_data = slot_data[i-1];
        end

        pipe_slot #(
            .CTRL_W    (CTRL_W),
            .DATA_W    (DATA_W),
            .ZERO_DATA (ZERO_DATA)
        ) u_slot (
            .Clk       (Clk),
            .Reset     (Reset),
            .clear     (flush),
            .load      (rdy[i]),
            .src_valid (src_vld),
            .src_ctrl  (src_ctrl),
            .src_data  (src_data),
            .valid     (slot_vld[i]),
            .ctrl      (slot_ctrl[i]),
            .data      (slot_data[i])
        );
    end

    assign in_ready  = rdy[0] & !flush & !Reset;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = slot_vld[DEPTH-1];
    assign out_ctrl  = slot_ctrl[DEPTH-1];
    assign out_data  = slot_data[DEPTH-1];
    assign out_xfer  = out_valid & out_ready;

    // Beats leaving during a flush cycle were seen downstream; the count restarts at zero anyway
    always_ff @(posedge Clk) begin
        if (Reset) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
module tb_elastic_pipe_reg;

    localparam int CW = 12;
    localparam int DW = 256;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          ir [3];
    logic          ov [3];
    logic [CW-1:0] oc [3];
    logic [DW-1:0] od [3];
    logic [1:0]    occ_a;
    logic [0:0]    occ_b;
    logic [2:0]    occ_c;
    int            occ [3];

    int checks;
    int errors;

    // Reference model: one FIFO of accepted beats per DUT, with acceptance cycle
    logic [CW-1:0] m_ctrl [3][8];
    logic [DW-1:0] m_data [3][8];
    int            m_acc  [3][8];
    int            m_head [3];
    int            m_cnt  [3];
    int            cyc;

    always #5 Clk = ~Clk;

    always_comb begin
        occ[0] = int'(occ_a);
        occ[1] = int'(occ_b);
        occ[2] = int'(occ_c);
    end

    elastic_pipe_reg #(.DEPTH(3), .CTRL_W(CW), .DATA_W(DW), .ZERO_DATA(1'b0)) u_d3 (
        .Clk(Clk), .Reset(Reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ_a));

    elastic_pipe_reg #(.DEPTH(1), .CTRL_W(CW), .DATA_W(DW), .ZERO_DATA(1'b0)) u_d1 (
        .Clk(Clk), .Reset(Reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ_b));

    elastic_pipe_reg #(.DEPTH(5), .CTRL_W(CW), .DATA_W(DW), .ZERO_DATA(1'b1)) u_d5 (
        .Clk(Clk), .Reset(Reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
        .out_ctrl(oc[2]), .out_data(od[2]), .occupancy(occ_c));

    function automatic int dep(input int d);
        return (d == 0) ? 3 : ((d == 1) ? 1 : 5);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++; if (ir[d] !== 1'b0) begin errors++; $display("FAIL reset_in_ready dut%0d got %b want 0", d, ir[d]); end
            checks++; if (ov[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d got %b want 0", d, ov[d]); end
            checks++; if (oc[d] !== '0) begin errors++; $display("FAIL reset_out_ctrl dut%0d got %h want 0", d, oc[d]); end
            checks++; if (occ[d] != 0) begin errors++; $display("FAIL reset_occupancy dut%0d got %0d want 0", d, occ[d]); end
            checks++; if (od[d] !== '0) begin errors++; $display("FAIL reset_out_data dut%0d got %h want 0", d, od[d]); end
        end
        Reset = 1'b0;
        #1;
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", ir[0]); end
    endtask

    task automatic test_stream();
        int acc, outn;
        logic exp_ov;
        out_ready = 1'b1;
        for (int t = 0; t < 15; t++) begin
            tick();
            in_valid = (t < 10); in_ctrl = 12'h001; in_data = DW'(t);
            #1;
            exp_ov = (t >= 3 && t < 13);
            acc  = (t < 10) ? t : 10;
            outn = (t > 3) ? (((t - 3) < 10) ? (t - 3) : 10) : 0;
            checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL stream_in_ready t=%0d got %b want 1", t, ir[0]); end
            checks++; if (ov[0] !== exp_ov) begin errors++; $display("FAIL stream_out_valid t=%0d got %b want %b", t, ov[0], exp_ov); end
            checks++; if (occ[0] != acc - outn) begin errors++; $display("FAIL stream_occupancy t=%0d got %0d want %0d", t, occ[0], acc - outn); end
            if (exp_ov) begin
                checks++; if (od[0] !== DW'(t - 3)) begin errors++; $display("FAIL stream_data t=%0d got %0h want %0h", t, od[0], t - 3); end
                checks++; if (oc[0] !== 12'h001) begin errors++; $display("FAIL stream_ctrl t=%0d got %h want 001", t, oc[0]); end
            end else begin
                checks++; if (oc[0] !== '0) begin errors++; $display("FAIL stream_idle_ctrl t=%0d got %h want 0", t, oc[0]); end
            end
        end
    endtask

    task automatic test_fill();
        int exp_occ;
        for (int t = 0; t < 10; t++) begin
            tick();
            in_valid = (t < 6); in_ctrl = 12'h002; in_data = DW'(100 + t); out_ready = (t >= 6);
            #1;
            exp_occ = (t < 3) ? t : ((t < 6) ? 3 : 3 - (t - 6));
            checks++; if (ir[0] !== ((t < 3) || (t >= 6))) begin errors++; $display("FAIL fill_in_ready t=%0d got %b want %b", t, ir[0], (t < 3) || (t >= 6)); end
            checks++; if (occ[0] != exp_occ) begin errors++; $display("FAIL fill_occupancy t=%0d got %0d want %0d", t, occ[0], exp_occ); end
            if (t >= 3) begin
                checks++; if (ov[0] !== (t <= 8)) begin errors++; $display("FAIL fill_out_valid t=%0d got %b want %b", t, ov[0], t <= 8); end
            end
            if (t >= 6 && t <= 8) begin
                checks++; if (od[0] !== DW'(100 + t - 6)) begin errors++; $display("FAIL fill_drain_data t=%0d got %0h want %0h", t, od[0], 100 + t - 6); end
            end
        end
    endtask

    task automatic test_bubble();
        for (int t = 0; t < 10; t++) begin
            tick();
            in_valid  = (t == 0 || t == 2);
            in_data   = (t == 0) ? DW'(200) : DW'(201);
            in_ctrl   = (t == 0) ? 12'h0A5 : 12'h15A;
            out_ready = (t >= 7);
            #1;
            if (!ov[0]) begin
                checks++; if (oc[0] !== '0) begin errors++; $display("FAIL bubble_idle_ctrl t=%0d got %h want 0", t, oc[0]); end
            end
            if (t == 2) begin
                checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL bubble_in_ready t=%0d got %b want 1", t, ir[0]); end
            end
            if (t == 7) begin
                checks++; if (occ[0] != 2) begin errors++; $display("FAIL bubble_occupancy got %0d want 2", occ[0]); end
                checks++; if (od[0] !== DW'(200) || oc[0] !== 12'h0A5) begin errors++; $display("FAIL bubble_first got %0h/%h want c8/0a5", od[0], oc[0]); end
            end
            if (t == 8) begin
                checks++; if (ov[0] !== 1'b1 || od[0] !== DW'(201) || oc[0] !== 12'h15A) begin errors++; $display("FAIL bubble_second got v=%b %0h/%h want 1 c9/15a", ov[0], od[0], oc[0]); end
            end
            if (t == 9) begin
                checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL bubble_drained got %b want 0", ov[0]); end
            end
        end
    endtask

    task automatic test_flush();
        int seen300;
        seen300 = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            in_valid = (t <= 3); in_ctrl = 12'h003;
            in_data  = (t < 3) ? DW'(300 + t) : DW'(399);
            flush    = (t == 3);
            #1;
            if (ov[0] && out_ready && od[0] === DW'(300)) seen300++;
            checks++; if (ov[0] && od[0] === DW'(399)) begin errors++; $display("FAIL flush_dropped_beat t=%0d got 399 want none", t); end
            if (t == 3) begin
                checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", ir[0]); end
                checks++; if (occ[0] != 3) begin errors++; $display("FAIL flush_pre_occupancy got %0d want 3", occ[0]); end
            end
            if (t >= 4) begin
                checks++; if (ov[0] !== 1'b0 || oc[0] !== '0) begin errors++; $display("FAIL flush_out_cleared t=%0d got v=%b c=%h want 0/0", t, ov[0], oc[0]); end
            end
            if (t == 4) begin
                for (int d = 0; d < 3; d++) begin
                    checks++; if (occ[d] != 0) begin errors++; $display("FAIL flush_occupancy dut%0d got %0d want 0", d, occ[d]); end
                end
                checks++; if (od[2] !== '0) begin errors++; $display("FAIL flush_zero_data got %h want 0", od[2]); end
            end
        end
        checks++; if (seen300 != 1) begin errors++; $display("FAIL flush_out_once got %0d want 1", seen300); end
    endtask

    task automatic test_reset_stall();
        out_ready = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            in_valid = (t < 2); in_ctrl = 12'h7FF; in_data = DW'(500 + t);
            Reset = (t == 4);
            #1;
            if (t == 4) begin
                checks++; if (occ[0] != 2) begin errors++; $display("FAIL rst_stall_occupancy got %0d want 2", occ[0]); end
                for (int d = 0; d < 3; d++) begin
                    checks++; if (ir[d] !== 1'b0) begin errors++; $display("FAIL rst_stall_in_ready dut%0d got %b want 0", d, ir[d]); end
                end
            end
            if (t == 5) begin
                for (int d = 0; d < 3; d++) begin
                    checks++; if (ov[d] !== 1'b0 || oc[d] !== '0) begin errors++; $display("FAIL rst_stall_out dut%0d got v=%b c=%h want 0/0", d, ov[d], oc[d]); end
                    checks++; if (occ[d] != 0) begin errors++; $display("FAIL rst_stall_occupancy_clr dut%0d got %0d want 0", d, occ[d]); end
                    checks++; if (od[d] !== '0) begin errors++; $display("FAIL rst_stall_data dut%0d got %h want 0", d, od[d]); end
                end
            end
        end
    endtask

    task automatic test_random(input int ncyc);
        logic exp_ir, exp_ov;
        logic in_x [3];
        logic out_x [3];
        int h, tl;
        tick();
        Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        Reset = 1'b0;
        cyc = 0;
        for (int d = 0; d < 3; d++) begin m_head[d] = 0; m_cnt[d] = 0; end
        for (int n = 0; n < ncyc; n++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_ctrl   = CW'($urandom);
            in_data   = rand_data();
            out_ready = (n < ncyc / 2) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 8);
            flush     = ($urandom_range(0, 99) == 0);
            #1;
            for (int d = 0; d < 3; d++) begin
                h = m_head[d];
                exp_ir = !flush && !(m_cnt[d] == dep(d) && !out_ready);
                exp_ov = (m_cnt[d] > 0) && (cyc - m_acc[d][h] >= dep(d));
                checks++; if (ir[d] !== exp_ir) begin errors++; $display("FAIL rand_in_ready dut%0d cyc=%0d got %b want %b", d, cyc, ir[d], exp_ir); end
                checks++; if (ov[d] !== exp_ov) begin errors++; $display("FAIL rand_out_valid dut%0d cyc=%0d got %b want %b", d, cyc, ov[d], exp_ov); end
                checks++; if (occ[d] != m_cnt[d]) begin errors++; $display("FAIL rand_occupancy dut%0d cyc=%0d got %0d want %0d", d, cyc, occ[d], m_cnt[d]); end
                if (exp_ov) begin
                    checks++; if (oc[d] !== m_ctrl[d][h] || od[d] !== m_data[d][h]) begin errors++; $display("FAIL rand_beat dut%0d cyc=%0d got %h/%h want %h/%h", d, cyc, oc[d], od[d], m_ctrl[d][h], m_data[d][h]); end
                end else begin
                    checks++; if (oc[d] !== '0) begin errors++; $display("FAIL rand_idle_ctrl dut%0d cyc=%0d got %h want 0", d, cyc, oc[d]); end
                end
                in_x[d]  = in_valid & exp_ir;
                out_x[d] = exp_ov & out_ready;
            end
            @(posedge Clk);
            for (int d = 0; d < 3; d++) begin
                if (flush) begin
                    m_head[d] = 0; m_cnt[d] = 0;
                end else begin
                    if (out_x[d]) begin m_head[d] = (m_head[d] + 1) % 8; m_cnt[d]--; end
                    if (in_x[d]) begin
                        tl = (m_head[d] + m_cnt[d]) % 8;
                        m_ctrl[d][tl] = in_ctrl; m_data[d][tl] = in_data; m_acc[d][tl] = cyc;
                        m_cnt[d]++;
                    end
                end
            end
            cyc++;
            #1;
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_fill();
        test_bubble();
        test_flush();
        test_reset_stall();
        test_random(10000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
